// File: rtl/div_ctrl.sv
// div_ctrl: sequencer for a 5-bit restoring-division datapath.
// Loads the dividend and then the divisor over the shared dataIN bus, runs five
// shift/subtract/restore iterations, then presents the quotient followed by
// the remainder on dataOUT through selOut.
// Optional feature macro: DIV_OV_CHECK_EN (sanity check of the final remainder).
//
// Handshake: ready is high only in IDLE. A request is taken when start = 1 in a
// cycle where ready = 1, and dataIN must carry the dividend in that same cycle
// and the divisor in the following cycle. start is ignored while ready = 0;
// nothing is queued.
module div_ctrl #(
  parameter int OUT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       A5,
  input  logic       OV,
  input  logic       DivByZero,
  input  logic       ContinueToDivision,
  output logic       ldA,
  output logic       ldQ,
  output logic       ldD,
  output logic       ldDbar,
  output logic       ldONE,
  output logic       shA,
  output logic       shQ,
  output logic       selA,
  output logic       selQ,
  output logic [1:0] sel1,
  output logic [1:0] sel2,
  output logic       selOut,
  output logic       clearA,
  output logic       clearQ,
  output logic       clearD,
  output logic       clearDbar,
  output logic       clearOne,
  output logic       AddCount,
  output logic       CounterClear,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       dbz,
  output logic       err,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD_D  = 4'd1,
    S_CHK     = 4'd2,
    S_DBZ     = 4'd3,
    S_NEG     = 4'd4,
    S_SHIFT   = 4'd5,
    S_SUB     = 4'd6,
    S_TEST    = 4'd7,
    S_RESTORE = 4'd8,
    S_SETQ    = 4'd9,
    S_NEXT    = 4'd10,
    S_OUT_Q   = 4'd11,
    S_OUT_R   = 4'd12
  } state_t;

  // Last value of the hold counter in a result phase.
  localparam logic [3:0] HOLD_LAST = 4'(OUT_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic       hold_end;

  assign hold_end = (hold_q == HOLD_LAST);
  assign state_o  = state_q;

  // State and result-phase hold counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hold_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic and Moore decode of every datapath control.
  always_comb begin
    state_d      = state_q;
    hold_d       = 4'd0;
    ldA          = 1'b0;
    ldQ          = 1'b0;
    ldD          = 1'b0;
    ldDbar       = 1'b0;
    ldONE        = 1'b0;
    shA          = 1'b0;
    shQ          = 1'b0;
    selA         = 1'b0;
    selQ         = 1'b0;
    sel1         = 2'b00;
    sel2         = 2'b00;
    selOut       = 1'b0;
    clearA       = 1'b0;
    clearQ       = 1'b0;
    clearD       = 1'b0;
    clearDbar    = 1'b0;
    clearOne     = 1'b0;
    AddCount     = 1'b0;
    CounterClear = 1'b0;
    ready        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    dbz          = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready        = 1'b1;
        clearA       = 1'b1;
        clearDbar    = 1'b1;
        CounterClear = 1'b1;
        if (start) begin
          selQ    = 1'b0;
          ldQ     = 1'b1;
          ldONE   = 1'b1;
          state_d = S_LOAD_D;
        end
      end
      S_LOAD_D: begin
        busy         = 1'b1;
        ldD          = 1'b1;
        CounterClear = 1'b1;
        state_d      = S_CHK;
      end
      S_CHK: begin
        busy    = 1'b1;
        state_d = DivByZero ? S_DBZ : S_NEG;
      end
      S_DBZ: begin
        dbz    = 1'b1;
        done   = 1'b1;
        selOut = 1'b1;
        if (hold_end) state_d = S_IDLE;
        else          hold_d  = hold_q + 4'd1;
      end
      S_NEG: begin
        busy    = 1'b1;
        sel1    = 2'b01;
        sel2    = 2'b10;
        ldDbar  = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        busy    = 1'b1;
        shA     = 1'b1;
        shQ     = 1'b1;
        state_d = S_SUB;
      end
      S_SUB: begin
        busy    = 1'b1;
        sel1    = 2'b10;
        sel2    = 2'b00;
        selA    = 1'b1;
        ldA     = 1'b1;
        state_d = S_TEST;
      end
      S_TEST: begin
        busy    = 1'b1;
        state_d = A5 ? S_RESTORE : S_SETQ;
      end
      S_RESTORE: begin
        busy     = 1'b1;
        sel1     = 2'b00;
        sel2     = 2'b00;
        selA     = 1'b1;
        ldA      = 1'b1;
        AddCount = 1'b1;
        state_d  = S_NEXT;
      end
      S_SETQ: begin
        busy     = 1'b1;
        sel1     = 2'b11;
        sel2     = 2'b01;
        selQ     = 1'b1;
        ldQ      = 1'b1;
        AddCount = 1'b1;
        state_d  = S_NEXT;
      end
      S_NEXT: begin
        busy    = 1'b1;
        state_d = ContinueToDivision ? S_SHIFT : S_OUT_Q;
      end
      S_OUT_Q: begin
        selOut = 1'b1;
        done   = 1'b1;
        if (hold_end) state_d = S_OUT_R;
        else          hold_d  = hold_q + 4'd1;
      end
      S_OUT_R: begin
        selOut = 1'b0;
        if (hold_end) state_d = S_IDLE;
        else          hold_d  = hold_q + 4'd1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // While reset is held the register controls stay quiet; only ready shows.
    if (!rst_n) begin
      clearA       = 1'b0;
      clearDbar    = 1'b0;
      CounterClear = 1'b0;
      ldQ          = 1'b0;
      ldONE        = 1'b0;
    end
  end

`ifdef DIV_OV_CHECK_EN
  logic err_q, err_d;

  // Sticky fault flag: set when the final remainder still reaches the divisor.
  always_comb begin
    err_d = err_q;
    if (state_q == S_IDLE && start)    err_d = 1'b0;
    else if (state_q == S_OUT_Q && OV) err_d = 1'b1;
  end

  // Fault flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_ov;
  assign unused_ov = OV;
  assign err       = 1'b0;
`endif

endmodule
